// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage with PC, return-address stack and
//            valid/ready instruction handoff to decode.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_sel,
    input  logic [15:0]       target,
    output logic              ras_err
);

    localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_RAS_FULL = c_CNT_W'(RAS_DEPTH);

    localparam logic [1:0] c_SEL_INC    = 2'b00;
    localparam logic [1:0] c_SEL_BRANCH = 2'b01;
    localparam logic [1:0] c_SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_instr;
    logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0]  r_sp;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;

    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_ras_top;
    logic                w_accept;
    logic                w_capture;
    logic                w_push;
    logic                w_pop;
    logic                w_ras_full;
    logic                w_ras_empty;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_ras_top   = r_ras[r_sp - c_PTR_W'(1)];
    assign w_ras_full  = (r_cnt == c_RAS_FULL);
    assign w_ras_empty = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_RESET: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    // Next-PC selection; decode inputs only matter on the accepting cycle.
    always_comb begin
        w_pc_nxt = r_pc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (w_accept) begin
            case (pc_sel)
                c_SEL_INC:    w_pc_nxt = w_pc_inc;
                c_SEL_BRANCH: w_pc_nxt = target[ADDR_W-1:0];
                c_SEL_JUMP: begin
                    w_push   = 1'b1;
                    w_pc_nxt = target[ADDR_W-1:0];
                end
                default: begin
                    w_pop    = 1'b1;
                    w_pc_nxt = w_ras_empty ? RESET_PC : w_ras_top;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_pc    <= RESET_PC;
            r_instr <= 16'h0000;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_pc <= w_pc_nxt;
            end
            // Full stack: pointer still advances so the oldest entry is overwritten.
            if (w_push) begin
                r_sp <= r_sp + c_PTR_W'(1);
                if (w_ras_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else if (w_pop) begin
                if (w_ras_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_sp  <= r_sp - c_PTR_W'(1);
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_ras[r_sp] <= w_pc_inc;
        end
    end

    generate
        if (ADDR_W < 16) begin : g_unused_target
            logic w_unused_target;
            assign w_unused_target = ^target[15:ADDR_W];
        end
    endgenerate

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == ST_HOLD);
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign ras_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed + random checks of fetch_unit against a queue-based model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int                ADDR_W    = 10;
    localparam int                RAS_DEPTH = 4;
    localparam logic [ADDR_W-1:0] RESET_PC  = '0;
    localparam int                PC_MOD    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [15:0]       imem_rdata = 16'h0;
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        pc_sel = 2'b00;
    logic [15:0]       target = 16'h0;
    logic              ras_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .pc_sel     (pc_sel),
        .target     (target),
        .ras_err    (ras_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = idle after reset, 1 = fetching, 2 = holding.
    int          m_phase = 0;
    int          m_pc = 0;
    logic [15:0] m_instr = 16'h0;
    int          m_ras[$];
    bit          m_err = 1'b0;
    bit          m_known = 1'b0;
    bit          m_accepted = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic a_rst, input logic a_ack, input logic a_rdy,
                              input logic [1:0] a_sel, input logic [15:0] a_tgt,
                              input logic [15:0] a_rdata);
        m_accepted = 1'b0;
        if (a_rst) begin
            m_known = 1'b1;
            m_phase = 0;
            m_pc    = int'(RESET_PC);
            m_instr = 16'h0;
            m_ras.delete();
            m_err   = 1'b0;
        end else if (m_known) begin
            case (m_phase)
                0: m_phase = 1;
                1: if (a_ack) begin
                    m_instr = a_rdata;
                    m_phase = 2;
                end
                default: if (a_rdy) begin
                    m_accepted = 1'b1;
                    m_phase    = 1;
                    case (a_sel)
                        2'b00: m_pc = (m_pc + 1) % PC_MOD;
                        2'b01: m_pc = int'(a_tgt) % PC_MOD;
                        2'b10: begin
                            if (m_ras.size() == RAS_DEPTH) begin
                                void'(m_ras.pop_front());
                                m_err = 1'b1;
                            end
                            m_ras.push_back((m_pc + 1) % PC_MOD);
                            m_pc = int'(a_tgt) % PC_MOD;
                        end
                        default: begin
                            if (m_ras.size() > 0) begin
                                m_pc = m_ras.pop_back();
                            end else begin
                                m_pc  = int'(RESET_PC);
                                m_err = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        if (m_known) begin
            check_eq("imem_req", 32'(imem_req), 32'(m_phase == 1));
            check_eq("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
            if (m_phase == 1) begin
                check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
            end
            check_eq("pc", 32'(pc), 32'(m_pc));
            check_eq("instr", 32'(instr), 32'(m_instr));
            check_eq("ras_err", 32'(ras_err), 32'(m_err));
        end
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic cycle(input logic a_rst, input logic a_ack, input logic a_rdy,
                         input logic [1:0] a_sel, input logic [15:0] a_tgt);
        logic [15:0] rd;
        rd          = 16'($urandom);
        rst         = a_rst;
        imem_ack    = a_ack;
        instr_ready = a_rdy;
        pc_sel      = a_sel;
        target      = a_tgt;
        imem_rdata  = rd;
        @(posedge clk);
        model_step(a_rst, a_ack, a_rdy, a_sel, a_tgt, rd);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic fetch_one(input logic [1:0] a_sel, input logic [15:0] a_tgt);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 1'b1, a_sel, a_tgt);
            if (m_accepted) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check_eq("fetch_timeout", 32'(done), 32'd1);
        end
    endtask

    logic [15:0] ret_exp [4];

    initial begin
        @(negedge clk);
        cycle(1'b1, 1'b1, 1'b1, 2'b00, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 2'b00, 16'h0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 16'h0);
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", 32'(imem_addr), 32'd0);

        repeat (3) fetch_one(2'b00, 16'h0);
        check_eq("inc_addr3", 32'(imem_addr), 32'h003);
        fetch_one(2'b01, 16'h03FF);
        fetch_one(2'b00, 16'h0);
        check_eq("inc_wrap", 32'(imem_addr), 32'h000);

        fetch_one(2'b01, 16'h0005);
        fetch_one(2'b01, 16'hFC20);
        check_eq("branch_trunc", 32'(imem_addr), 32'h020);

        cycle(1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
        repeat (2) fetch_one(2'b00, 16'h0);
        fetch_one(2'b10, 16'h0040);
        fetch_one(2'b10, 16'h0080);
        fetch_one(2'b11, 16'hFFFF);
        check_eq("ret1_addr", 32'(imem_addr), 32'h041);
        fetch_one(2'b11, 16'hFFFF);
        check_eq("ret2_addr", 32'(imem_addr), 32'h003);
        check_eq("ret_no_err", 32'(ras_err), 32'd0);

        cycle(1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
        fetch_one(2'b11, 16'h0123);
        check_eq("underflow_addr", 32'(imem_addr), 32'(RESET_PC));
        check_eq("underflow_err", 32'(ras_err), 32'd1);

        cycle(1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 5; i++) fetch_one(2'b10, 16'((i + 1) * 16));
        check_eq("overflow_err", 32'(ras_err), 32'd1);
        ret_exp[0] = 16'h041; ret_exp[1] = 16'h031;
        ret_exp[2] = 16'h021; ret_exp[3] = 16'h011;
        for (int i = 0; i < 4; i++) begin
            fetch_one(2'b11, 16'h0);
            check_eq("lifo_ret", 32'(imem_addr), 32'(ret_exp[i]));
        end

        cycle(1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
        fetch_one(2'b10, 16'h0100);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 2'b01, 16'h0200);
        check_eq("stall_addr", 32'(imem_addr), 32'h100);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 16'h0200);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 2'b01, 16'h0200);
        check_eq("hold_valid", 32'(instr_valid), 32'd1);
        check_eq("hold_pc", 32'(pc), 32'h100);
        cycle(1'b1, 1'b1, 1'b1, 2'b10, 16'h0300);
        check_eq("rst_hold_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_hold_pc", 32'(pc), 32'(RESET_PC));
        fetch_one(2'b11, 16'h0);
        check_eq("rst_ras_empty", 32'(ras_err), 32'd1);

        cycle(1'b1, 1'b0, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                  2'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
